// File: rtl/sprite_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_fetch_arbiter
// Purpose  : Round-robin arbiter that lets several sprite lanes share one
//            block ROM. The winning lane's sprite/row is turned into a ROM
//            address (stage 1), then the ROM row is registered and presented
//            to a ready/valid consumer (stage 2).
// Revision : 1.0 - initial release
// ============================================================================
module sprite_fetch_arbiter #(
  parameter int NUM_LANES   = 5,
  parameter int SPRITE_ROWS = 18,
  parameter int ROM_AW      = 8
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [NUM_LANES-1:0]   req,
  input  logic [2*NUM_LANES-1:0] sel,
  input  logic [5*NUM_LANES-1:0] row,
  output logic [NUM_LANES-1:0]   gnt,
  output logic [ROM_AW-1:0]      rom_addr,
  input  logic [31:0]            rom_data,
  output logic [31:0]            pix_data,
  output logic [2:0]             pix_lane,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic                   oob
);

  localparam int IW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  // Round-robin pointer and stage-1 (address issued, ROM data pending) state
  logic [IW-1:0]        last_lane;
  logic                 s1_valid;
  logic [IW-1:0]        s1_lane;
  logic                 s1_oob;

  // Arbitration results for the current cycle
  logic                 advance;
  logic [NUM_LANES-1:0] eligible;
  logic [IW-1:0]        cand;
  logic                 win_found;
  logic [IW-1:0]        win_lane;
  logic [1:0]           win_sel;
  logic [4:0]           win_row;
  logic                 win_oob;
  logic [ROM_AW-1:0]    win_addr;
  logic [NUM_LANES-1:0] win_onehot;

  // The pipeline moves only when the output slot is empty or being accepted;
  // a stalled output freezes stage 1 and suppresses new grants.
  assign advance = !pix_valid || pix_ready;

  // Search lanes starting just after the last winner; a lane whose grant is
  // currently showing is skipped so a held request cannot win back-to-back.
  always_comb begin
    eligible  = req & ~gnt;
    cand      = '0;
    win_found = 1'b0;
    win_lane  = '0;
    for (int i = 1; i <= NUM_LANES; i++) begin
      cand = IW'((int'(last_lane) + i) % NUM_LANES);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_lane  = cand;
      end
    end
  end

  // Pick up the winner's sprite/row and form the ROM address; rows past the
  // end of a sprite are fetched from address 0 and flagged out-of-bounds.
  always_comb begin
    win_sel    = '0;
    win_row    = '0;
    win_onehot = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (win_lane == IW'(k)) begin
        win_sel       = sel[2*k +: 2];
        win_row       = row[5*k +: 5];
        win_onehot[k] = win_found;
      end
    end
    win_oob  = int'(win_row) >= SPRITE_ROWS;
    win_addr = win_oob ? '0 : ROM_AW'(int'(win_sel) * SPRITE_ROWS + int'(win_row));
  end

  // Stage 1: register the grant pulse, ROM address and in-flight lane info.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      gnt       <= '0;
      rom_addr  <= '0;
      s1_valid  <= 1'b0;
      s1_lane   <= '0;
      s1_oob    <= 1'b0;
      last_lane <= IW'(NUM_LANES - 1);
    end else if (advance) begin
      gnt      <= win_onehot;
      s1_valid <= win_found;
      if (win_found) begin
        rom_addr  <= win_addr;
        s1_lane   <= win_lane;
        s1_oob    <= win_oob;
        last_lane <= win_lane;
      end
    end else begin
      gnt <= '0;
    end
  end

  // Stage 2: capture the ROM row into the output register when it can move.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_lane  <= '0;
      oob       <= 1'b0;
    end else if (advance) begin
      pix_valid <= s1_valid;
      oob       <= s1_valid && s1_oob;
      if (s1_valid) begin
        pix_data <= s1_oob ? '0 : rom_data;
        pix_lane <= 3'(s1_lane);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_fetch_arbiter
// Purpose  : Directed self-checking bench for sprite_fetch_arbiter with a
//            transaction-level reference model and per-cycle comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_fetch_arbiter;

  localparam int N    = 5;
  localparam int ROWS = 18;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [2*N-1:0] sel = '0;
  logic [5*N-1:0] row = '0;
  logic [N-1:0]   gnt;
  logic [7:0]     rom_addr;
  logic [31:0]    rom_data;
  logic [31:0]    pix_data;
  logic [2:0]     pix_lane;
  logic           pix_valid;
  logic           pix_ready = 1'b1;
  logic           oob;

  int n_checks = 0;
  int n_fail   = 0;

  sprite_fetch_arbiter #(.NUM_LANES(N), .SPRITE_ROWS(ROWS), .ROM_AW(8)) dut (
    .Clk(clk), .Reset_n(rst_n), .req(req), .sel(sel), .row(row), .gnt(gnt),
    .rom_addr(rom_addr), .rom_data(rom_data), .pix_data(pix_data),
    .pix_lane(pix_lane), .pix_valid(pix_valid), .pix_ready(pix_ready), .oob(oob)
  );

  always #5 clk = ~clk;

  // ROM contents: two pinned rows, everything else a recognisable pattern
  function automatic logic [31:0] rom_fn(input logic [7:0] a);
    case (a)
      8'd19:   return 32'h3FFF_FFFC;
      8'd58:   return 32'h0FFF_FFF0;
      default: return {a, ~a, a ^ 8'h5A, 8'hC3};
    endcase
  endfunction

  assign rom_data = rom_fn(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic set_lane(input int l, input logic r, input logic [1:0] s, input logic [4:0] rw);
    req[l]         = r;
    sel[2*l +: 2]  = s;
    row[5*l +: 5]  = rw;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    logic [2:0]  lane;
    logic        oob;
  } ent_t;

  ent_t        pend[$];
  ent_t        e;
  int          m_last = N - 1;
  logic [N-1:0] m_gnt = '0;
  logic [7:0]  m_addr = '0;
  logic        m_out_v = 1'b0;
  logic [31:0] m_out_data = '0;
  logic [2:0]  m_out_lane = '0;
  logic        m_out_oob = 1'b0;
  int          m_w, m_l, m_a, m_s, m_r;
  bit          m_found;

  // Each cycle: if the output slot frees, the fetched entry moves out and the
  // next round-robin winner (skipping the lane just granted) is issued.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      m_last = N - 1; m_gnt = '0; m_addr = '0;
      m_out_v = 1'b0; m_out_data = '0; m_out_lane = '0; m_out_oob = 1'b0;
    end else if (!m_out_v || pix_ready) begin
      if (pend.size() > 0) begin
        e = pend.pop_front();
        m_out_v = 1'b1; m_out_data = e.data; m_out_lane = e.lane; m_out_oob = e.oob;
      end else begin
        m_out_v = 1'b0;
      end
      m_found = 1'b0;
      m_w = 0;
      for (int o = 1; o <= N; o++) begin
        m_l = (m_last + o) % N;
        if (!m_found && req[m_l] && !m_gnt[m_l]) begin
          m_found = 1'b1;
          m_w = m_l;
        end
      end
      if (m_found) begin
        m_s = int'(sel[2*m_w +: 2]);
        m_r = int'(row[5*m_w +: 5]);
        e.oob  = (m_r >= ROWS);
        m_a    = e.oob ? 0 : ((m_s * ROWS + m_r) % 256);
        e.data = e.oob ? 32'h0 : rom_fn(8'(m_a));
        e.lane = 3'(m_w);
        pend.push_back(e);
        m_addr = 8'(m_a);
        m_gnt  = N'(1 << m_w);
        m_last = m_w;
      end else begin
        m_gnt = '0;
      end
    end else begin
      m_gnt = '0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("gnt", 32'(gnt), 32'(m_gnt));
      check("rom_addr", 32'(rom_addr), 32'(m_addr));
      check("pix_valid", 32'(pix_valid), 32'(m_out_v));
      check("oob", 32'(oob), 32'(m_out_v & m_out_oob));
      if (m_out_v) begin
        check("pix_data", pix_data, m_out_data);
        check("pix_lane", 32'(pix_lane), 32'(m_out_lane));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [15:0] rdy_pat;

  initial begin
    rdy_pat = 16'b1011_0011_1010_1101;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_pix_valid", 32'(pix_valid), 32'h0);
    check("rst_rom_addr", 32'(rom_addr), 32'h0);
    check("rst_pix_data", pix_data, 32'h0);
    check("rst_oob", 32'(oob), 32'h0);
    rst_n = 1'b1;

    // Single fetch: lane 2, sprite 1, row 1
    @(negedge clk);
    set_lane(2, 1'b1, 2'd1, 5'd1);
    @(negedge clk);
    check("t1_gnt", 32'(gnt), 32'h04);
    check("t1_addr", 32'(rom_addr), 32'd19);
    check("t1_model_addr", 32'(m_addr), 32'd19);
    set_lane(2, 1'b0, 2'd1, 5'd1);
    @(negedge clk);
    check("t1_valid", 32'(pix_valid), 32'h1);
    check("t1_data", pix_data, 32'h3FFF_FFFC);
    check("t1_lane", 32'(pix_lane), 32'd2);
    repeat (2) @(negedge clk);

    // Full contention from a fresh reset: 0,1,2,3,4,0
    rst_n = 1'b0;
    @(negedge clk);
    for (int l = 0; l < N; l++) set_lane(l, 1'b1, 2'(l % 4), 5'(l + 2));
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_gnt", 32'(gnt), 32'(1 << (i % N)));
      if (i > 0) check("rr_valid", 32'(pix_valid), 32'h1);
    end
    req = '0;
    repeat (3) @(negedge clk);

    // Stall: lane 0 sprite 3 row 4 held while pix_ready is low
    pix_ready = 1'b0;
    set_lane(0, 1'b1, 2'd3, 5'd4);
    @(negedge clk);
    check("st_gnt", 32'(gnt), 32'h01);
    check("st_addr", 32'(rom_addr), 32'd58);
    set_lane(0, 1'b0, 2'd3, 5'd4);
    @(negedge clk);
    set_lane(1, 1'b1, 2'd1, 5'd2);
    for (int i = 0; i < 3; i++) begin
      check("st_hold_valid", 32'(pix_valid), 32'h1);
      check("st_hold_data", pix_data, 32'h0FFF_FFF0);
      check("st_hold_gnt", 32'(gnt), 32'h0);
      check("st_hold_addr", 32'(rom_addr), 32'd58);
      @(negedge clk);
    end
    pix_ready = 1'b1;
    @(negedge clk);
    check("st_resume_gnt", 32'(gnt), 32'h02);
    set_lane(1, 1'b0, 2'd1, 5'd2);
    repeat (3) @(negedge clk);

    // Out-of-bounds row
    set_lane(1, 1'b1, 2'd2, 5'd20);
    @(negedge clk);
    check("oob_gnt", 32'(gnt), 32'h02);
    check("oob_addr", 32'(rom_addr), 32'd0);
    set_lane(1, 1'b0, 2'd2, 5'd20);
    @(negedge clk);
    check("oob_valid", 32'(pix_valid), 32'h1);
    check("oob_flag", 32'(oob), 32'h1);
    check("oob_data", pix_data, 32'h0);
    @(negedge clk);
    check("oob_pulse_end", 32'(oob), 32'h0);
    repeat (2) @(negedge clk);

    // Held request is granted at most every second cycle
    set_lane(3, 1'b1, 2'd2, 5'd5);
    @(negedge clk);
    check("mask_gnt0", 32'(gnt), 32'h08);
    @(negedge clk);
    check("mask_gnt1", 32'(gnt), 32'h00);
    @(negedge clk);
    check("mask_gnt2", 32'(gnt), 32'h08);
    req = '0;
    repeat (3) @(negedge clk);

    // Mixed traffic with intermittent back-pressure, including row 17 and 18
    set_lane(1, 1'b1, 2'd1, 5'd9);
    set_lane(3, 1'b1, 2'd3, 5'd18);
    set_lane(4, 1'b1, 2'd2, 5'd17);
    for (int i = 0; i < 16; i++) begin
      pix_ready = rdy_pat[i];
      @(negedge clk);
    end
    req = '0;
    pix_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Asynchronous reset while an entry is presented
    pix_ready = 1'b0;
    set_lane(2, 1'b1, 2'd1, 5'd1);
    @(negedge clk);
    set_lane(2, 1'b0, 2'd1, 5'd1);
    @(negedge clk);
    check("ar_pre_valid", 32'(pix_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(pix_valid), 32'h0);
    check("ar_gnt", 32'(gnt), 32'h0);
    check("ar_oob", 32'(oob), 32'h0);
    check("ar_addr", 32'(rom_addr), 32'h0);
    @(negedge clk);
    set_lane(0, 1'b1, 2'd1, 5'd3);
    set_lane(3, 1'b1, 2'd2, 5'd6);
    pix_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_first_gnt", 32'(gnt), 32'h01);
    req = '0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_fetch_arbiter.md
SPRITE_FETCH_ARBITER -- requirements
Module: sprite_fetch_arbiter

Interface
REQ-001 SHALL have parameter NUM_LANES, default 5, meaning the number of requesting lanes sharing the block ROM.
REQ-002 SHALL have parameter SPRITE_ROWS, default 18, meaning the rows per sprite in the ROM.
REQ-003 SHALL have parameter ROM_AW, default 8, meaning the ROM address width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: Clk  input  1  rising-edge clock, all state sampled on it.
REQ-005 SHALL have Reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have req  input  NUM_LANES  per-lane level request, bit i = lane i.
REQ-007 SHALL have sel  input  2*NUM_LANES  per-lane sprite select: 0 empty, 1 unpressed, 2 pressed, 3 note.
REQ-008 SHALL have row  input  5*NUM_LANES  per-lane sprite row index.
REQ-009 SHALL have gnt  output  NUM_LANES  one-hot registered grant.
REQ-010 SHALL have rom_addr  output  ROM_AW  address to the block ROM.
REQ-011 SHALL have rom_data  input  32  combinational ROM row data.
REQ-012 SHALL have pix_data  output  32  fetched sprite row.
REQ-013 SHALL have pix_lane  output  3  lane index of pix_data.
REQ-014 SHALL have pix_valid  output  1  pix_data/pix_lane valid.
REQ-015 SHALL have pix_ready  input  1  downstream accepts pix_data when high with pix_valid.
REQ-016 SHALL have oob  output  1  one-cycle pulse, delivered row had row >= SPRITE_ROWS.

Function
REQ-017 SHALL grant at most one lane per cycle, round-robin: search starts at the lane after the last granted lane, wrapping NUM_LANES-1 to 0.
REQ-018 SHALL mask from arbitration the lane whose gnt bit is currently high (same lane at most every 2nd cycle).
REQ-019 SHALL sample req/sel/row in arbitration cycle N; register gnt, rom_addr and stage-1 valid/lane so they are valid in cycle N+1.
REQ-020 SHALL hold gnt high for exactly one cycle per grant; requester keeps sel/row stable until gnt and may drop req in the gnt cycle.
REQ-021 SHALL compute rom_addr = sel*SPRITE_ROWS + row (sel*16 + sel*2 + row), truncated to ROM_AW bits.
REQ-022 SHALL, for row >= SPRITE_ROWS, drive rom_addr = 0, force pix_data = 0 for that entry, and pulse oob with its pix_valid.
REQ-023 SHALL register rom_data into pix_data at end of cycle N+1; pix_valid high from cycle N+2 (latency 2 from request sampling).
REQ-024 SHALL sustain one delivered row per cycle when pix_ready is high and requests are pending.
REQ-025 SHALL, when pix_valid=1 and pix_ready=0, hold pix_data/pix_lane/pix_valid/oob, hold stage 1 (rom_addr stable), and issue no grant.
REQ-026 SHALL resume arbitration in the cycle after pix_ready returns high, with the round-robin pointer unchanged by the stall.
REQ-027 SHALL with no req pending keep gnt = 0, rom_addr at last value, and clear pix_valid once the current entry is accepted.
REQ-028 SHALL treat req bits for lane >= NUM_LANES as non-existent; pix_lane SHALL always be < NUM_LANES.

Reset
REQ-029 SHALL on Reset_n low immediately clear gnt, pix_valid, oob, stage-1 valid, pix_data, pix_lane and rom_addr to 0, and set the round-robin pointer so lane 0 wins first.
REQ-030 SHALL discard in-flight fetches on mid-operation reset; first grant after release occurs in the first cycle Reset_n is sampled high with req set.

Verification
REQ-031 SHALL pass: lane 2 req, sel=1, row=1 -> gnt=00100 next cycle, rom_addr=19, pix_data=0x3FFFFFFC, pix_lane=2 two cycles after req.
REQ-032 SHALL pass: all 5 lanes req continuously, pix_ready=1 -> grants 0,1,2,3,4,0 in consecutive cycles, one pix_valid per cycle.
REQ-033 SHALL pass: lane 0 sel=3, row=4 while pix_ready=0 for 3 cycles -> rom_addr=58, pix_data=0x0FFFFFF0 held, no gnt during stall.
REQ-034 SHALL pass: lane 1 sel=2, row=20 -> rom_addr=0, pix_data=0, oob pulsed with pix_valid.
REQ-035 SHALL pass: Reset_n low with pix_valid=1 -> pix_valid, gnt, oob 0 asynchronously; after release lane 0 wins a 0+3 contest.
